serial_adder_ctrl: RTL



---
 rtl/serial_adder_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in with a single time-shared
//   1-bit full-adder cell. One bit is processed per clock, LSB first. A
//   start/busy/done handshake is used towards the requester.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request pulse, sampled only when busy=0 (IDLE or DONE)
//   a      in   WIDTH  operand A, latched on accepted start
//   b      in   WIDTH  operand B, latched on accepted start
//   cin    in   1      carry-in, latched on accepted start
//   busy   out  1      high while an addition is in progress
//   done   out  1      one-cycle pulse when sum/cout are valid
//   sum    out  WIDTH  registered result, holds until the next completion
//   cout   out  1      registered carry-out, holds until the next completion
//   ovf    out  1      (only with SERIAL_ADDER_OVF_EN) signed overflow,
//                      registered alongside sum/cout
//
// Configuration:
//   SERIAL_ADDER_OVF_EN - when defined, adds the ovf output port and logic.
//
// Timing:
//   start accepted at edge E0 -> WIDTH RUN cycles -> done high in the cycle
//   after edge E0+WIDTH. A start seen in DONE is accepted immediately, giving
//   one result per WIDTH+1 cycles.
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] part_q, part_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Shared full-adder cell: always looks at the current LSBs and carry flop.
    logic fa_s;
    logic fa_c;

    always_comb begin
        fa_s = a_q[0] ^ b_q[0] ^ carry_q;
        fa_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
    end

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        part_d  = part_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        busy    = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                busy    = 1'b1;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = fa_c;
                // Sum bits enter at the MSB; after WIDTH shifts bit 0 has
                // migrated down to position 0.
                part_d  = {fa_s, part_q[WIDTH-1:1]};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Final bit: publish the result including this bit.
                    sum_d   = {fa_s, part_q[WIDTH-1:1]};
                    cout_d  = fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB, fa_c the carry out.
                    ovf_d   = carry_q ^ fa_c;
`endif
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    // Back-to-back acceptance without passing through IDLE.
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    part_d  = '0;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            part_q  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            part_q  <= part_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
